if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core: owns the PC, issues word fetches to instruction memory and buffers the returned instruction.
- Hands the instruction plus PC+4 to the IF/ID pipeline register through a load-enable (`IF_ID_sel`) and a flush strobe.
- Honours hazard-unit stalls and branch/jump redirects from later stages; wrong-path fetches still in flight are discarded.

---
 rtl/if_fetch_stage.sv | 139 +++++++++++++
 tb/tb_if_fetch_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction-fetch stage: PC, single-outstanding imem fetch, IF/ID handoff
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        IF_ID_sel,
  output logic        flush
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] discard_count
`endif
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    VALID   = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_buf_q, instr_buf_d;
  logic [31:0] pc4_buf_q, pc4_buf_d;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        handoff;
  logic        drop;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign pc_plus4        = pc_q + 32'd4;
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // Overlapped fetch: the handoff cycle already requests the next word.
  assign handoff   = (state_q == VALID) && !stall && !redirect;
  assign IF_ID_sel = !rst && handoff;
  assign flush     = !rst && redirect;
  assign imem_req  = !rst && ((state_q == FETCH) || handoff);
  assign imem_addr = (state_q == VALID) ? pc_plus4 : pc_q;

  assign if_instr    = instr_buf_q;
  assign if_pc_plus4 = pc4_buf_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_buf_d = instr_buf_q;
    pc4_buf_d   = pc4_buf_q;
    drop        = 1'b0;
    case (state_q)
      FETCH: begin
        state_d = redirect ? DISCARD : WAIT;
      end
      WAIT: begin
        if (redirect) begin
          state_d = imem_rvalid ? FETCH : DISCARD;
          drop    = imem_rvalid;
        end else if (imem_rvalid) begin
          instr_buf_d = imem_rdata;
          pc4_buf_d   = pc_plus4;
          state_d     = VALID;
        end
      end
      VALID: begin
        if (redirect) begin
          state_d = FETCH;
          drop    = 1'b1;
        end else if (!stall) begin
          pc_d    = pc_plus4;
          state_d = WAIT;
        end
      end
      DISCARD: begin
        if (imem_rvalid) begin
          state_d = FETCH;
          drop    = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase
    if (redirect) begin
      pc_d = redirect_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      instr_buf_q <= 32'd0;
      pc4_buf_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_buf_q <= instr_buf_d;
      pc4_buf_q   <= pc4_buf_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] discard_count_q, discard_count_d;

  always_comb begin
    fetch_count_d   = fetch_count_q + {31'd0, handoff};
    discard_count_d = discard_count_q + {31'd0, drop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q   <= 32'd0;
      discard_count_q <= 32'd0;
    end else begin
      fetch_count_q   <= fetch_count_d;
      discard_count_q <= discard_count_d;
    end
  end

  assign fetch_count   = fetch_count_q;
  assign discard_count = discard_count_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed bench for if_fetch_stage with a variable-latency imem model
module tb_if_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        IF_ID_sel;
  logic        flush;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] discard_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int lat   = 1;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_pc_plus4 (if_pc_plus4),
    .if_instr    (if_instr),
    .IF_ID_sel   (IF_ID_sel),
    .flush       (flush)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .discard_count (discard_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory answers each request lat cycles later with addr ^ KEY.
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_pend    <= 1'b0;
      mem_cnt     <= 0;
      mem_addr    <= 32'd0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'd0;
    end else begin
      imem_rvalid <= 1'b0;
      if (mem_pend) begin
        if (mem_cnt == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_addr ^ KEY;
          mem_pend    <= 1'b0;
        end
        mem_cnt <= mem_cnt - 1;
      end
      if (imem_req) begin
        mem_addr <= imem_addr;
        if (lat == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= imem_addr ^ KEY;
        end else begin
          mem_pend <= 1'b1;
          mem_cnt  <= lat - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] fexp, input logic [31:0] dexp);
`ifdef IF_PERF_CNT_EN
    chk({tag, "_fetch_count"}, fetch_count, fexp);
    chk({tag, "_discard_count"}, discard_count, dexp);
`else
    if (fexp !== dexp && tag.len() == 0) n_cmp = n_cmp;
`endif
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h44;
    tick(); tick(); #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_sel", {31'd0, IF_ID_sel}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc4", if_pc_plus4, 32'd0);
    redirect = 1'b0; rst = 1'b0; #1;
    chk("c0_req", {31'd0, imem_req}, 32'd1);
    chk("c0_addr", imem_addr, 32'h0);
    chk("c0_sel", {31'd0, IF_ID_sel}, 32'd0);
    tick(); #1;
    chk("c1_req", {31'd0, imem_req}, 32'd0);
    chk("c1_sel", {31'd0, IF_ID_sel}, 32'd0);
    tick(); #1;
    chk("c2_sel", {31'd0, IF_ID_sel}, 32'd1);
    chk("c2_instr", if_instr, 32'hA5A5_0000);
    chk("c2_pc4", if_pc_plus4, 32'h4);
    chk("c2_req", {31'd0, imem_req}, 32'd1);
    chk("c2_addr", imem_addr, 32'h4);
    tick(); #1;
    chk("c3_sel", {31'd0, IF_ID_sel}, 32'd0);
    chk("c3_req", {31'd0, imem_req}, 32'd0);
    tick(); stall = 1'b1; #1;
    chk("stall0_sel", {31'd0, IF_ID_sel}, 32'd0);
    chk("stall0_req", {31'd0, imem_req}, 32'd0);
    chk("stall0_instr", if_instr, 32'hA5A5_0004);
    chk("stall0_pc4", if_pc_plus4, 32'h8);
    for (int i = 1; i < 3; i++) begin
      tick(); #1;
      chk($sformatf("stall%0d_sel", i), {31'd0, IF_ID_sel}, 32'd0);
      chk($sformatf("stall%0d_req", i), {31'd0, imem_req}, 32'd0);
      chk($sformatf("stall%0d_instr", i), if_instr, 32'hA5A5_0004);
    end
    tick(); stall = 1'b0; #1;
    chk("c7_sel", {31'd0, IF_ID_sel}, 32'd1);
    chk("c7_instr", if_instr, 32'hA5A5_0004);
    chk("c7_addr", imem_addr, 32'h8);
    tick(); #1;
    chk("c8_sel", {31'd0, IF_ID_sel}, 32'd0);
    tick(); lat = 3; #1;
    chk("c9_sel", {31'd0, IF_ID_sel}, 32'd1);
    chk("c9_instr", if_instr, 32'hA5A5_0008);
    chk("c9_pc4", if_pc_plus4, 32'hC);
    chk("c9_addr", imem_addr, 32'hC);
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
    chk("wait_redir_flush", {31'd0, flush}, 32'd1);
    chk("wait_redir_sel", {31'd0, IF_ID_sel}, 32'd0);
    chk("wait_redir_req", {31'd0, imem_req}, 32'd0);
    tick(); redirect = 1'b0; #1;
    chk("disc_flush", {31'd0, flush}, 32'd0);
    chk("disc_req", {31'd0, imem_req}, 32'd0);
    tick(); #1;
    chk("disc_rvalid_req", {31'd0, imem_req}, 32'd0);
    chk("disc_rvalid_sel", {31'd0, IF_ID_sel}, 32'd0);
    tick(); #1;
    chk("tgt_req", {31'd0, imem_req}, 32'd1);
    chk("tgt_addr", imem_addr, 32'h100);
    chk_cnt("after_disc", 32'd3, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk($sformatf("lat3_wait%0d_sel", i), {31'd0, IF_ID_sel}, 32'd0);
    end
    tick(); stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; #1;
    chk("sr_flush", {31'd0, flush}, 32'd1);
    chk("sr_sel", {31'd0, IF_ID_sel}, 32'd0);
    chk("sr_req", {31'd0, imem_req}, 32'd0);
    chk("sr_instr", if_instr, 32'hA5A5_0100);
    chk("sr_pc4", if_pc_plus4, 32'h104);
    tick(); stall = 1'b0; redirect = 1'b0; #1;
    chk("sr_next_req", {31'd0, imem_req}, 32'd1);
    chk("sr_next_addr", imem_addr, 32'h200);
    chk_cnt("after_sr", 32'd3, 32'd2);
    tick(); rst = 1'b1; #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_sel", {31'd0, IF_ID_sel}, 32'd0);
    chk("midrst_instr", if_instr, 32'd0);
    chk("midrst_pc4", if_pc_plus4, 32'd0);
    tick(); rst = 1'b0; lat = 1; #1;
    chk("postrst_req", {31'd0, imem_req}, 32'd1);
    chk("postrst_addr", imem_addr, 32'h0);
    chk_cnt("postrst", 32'd0, 32'd0);
    tick(); #1;
    chk("postrst_wait_sel", {31'd0, IF_ID_sel}, 32'd0);
    tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
    chk("valid_redir_flush", {31'd0, flush}, 32'd1);
    chk("valid_redir_sel", {31'd0, IF_ID_sel}, 32'd0);
    chk("valid_redir_instr", if_instr, 32'hA5A5_0000);
    tick(); redirect = 1'b0; #1;
    chk("top_req", {31'd0, imem_req}, 32'd1);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); #1;
    chk("top_wait_sel", {31'd0, IF_ID_sel}, 32'd0);
    tick(); #1;
    chk("wrap_sel", {31'd0, IF_ID_sel}, 32'd1);
    chk("wrap_instr", if_instr, 32'h5A5A_FFFC);
    chk("wrap_pc4", if_pc_plus4, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    tick(); redirect = 1'b1; redirect_pc = 32'h40; #1;
    chk("wr_flush", {31'd0, flush}, 32'd1);
    chk("wr_sel", {31'd0, IF_ID_sel}, 32'd0);
    chk("wr_req", {31'd0, imem_req}, 32'd0);
    tick(); redirect = 1'b0; #1;
    chk("wr_next_req", {31'd0, imem_req}, 32'd1);
    chk("wr_next_addr", imem_addr, 32'h40);
    chk_cnt("final", 32'd1, 32'd2);
    tick(); #1;
    chk("wr_wait_sel", {31'd0, IF_ID_sel}, 32'd0);
    tick(); #1;
    chk("wr_sel_final", {31'd0, IF_ID_sel}, 32'd1);
    chk("wr_instr", if_instr, 32'hA5A5_0040);
    chk("wr_pc4", if_pc_plus4, 32'h44);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
